sprite_plotter: RTL and testbench
=================================

Name: sprite_plotter

Overview:
- Parametrised successor to the fixed-shape symbol drawers.
- Scans a SPR_W x SPR_H one-bit bitmap in row-major order, one cell per clock, and emits VGA-adapter plot requests (x, y, colour, plot) for every set cell, offset from a latched base coordinate.
- Adds a start/busy/done handshake, runtime bitmap input, foreground colour and erase mode.
- Sits between the game-logic FSM and the vga_adapter write port.

Parameters:
- SPR_W, 16, sprite width in pixels (>=1).
- SPR_H, 16, sprite height in pixels (>=1).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COL_W, 3, colour width.
- BG_COLOUR, 0, colour driven in erase mode.
- SCR_W, 160, screen width (used only with SPRITE_CLIP_EN).
- SCR_H, 120, screen height (used only with SPRITE_CLIP_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to draw; sampled only in IDLE.
- x_base  input  X_W  sprite top-left x; latched on accept.
- y_base  input  Y_W  sprite top-left y; latched on accept.
- bitmap  input  SPR_W*SPR_H  bit r*SPR_W+c = cell (c,r); latched on accept.
- fg_colour  input  COL_W  draw colour; latched on accept.
- erase  input  1  1 = draw set cells in BG_COLOUR; latched on accept.
- xout  output  X_W  plot x.
- yout  output  Y_W  plot y.
- colour  output  COL_W  plot colour.
- plot  output  1  write strobe to the VGA adapter.
- busy  output  1  high while a draw is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; xout, yout, colour, plot, busy, done all 0; counters cleared. Reset mid-draw aborts the draw immediately: no done pulse, and the latched bitmap is discarded.
- States:
  - IDLE: start=1 at edge E0 latches all inputs, clears c=0 and r=0, sets busy=1, and goes to SCAN.
  - SCAN: handles cell n = r*SPR_W + c at edge E(n+1). Registers xout = x_base + c and yout = y_base + r, each truncated to X_W/Y_W (modulo wrap). Registers colour = erase ? BG_COLOUR : fg_colour, and plot = bitmap[n].
    - c increments; at c = SPR_W-1, c returns to 0 and r increments.
    - After cell N-1, where N = SPR_W*SPR_H, go to DONE.
  - DONE: at edge E(N+1), plot=0, busy=0, done=1 for exactly one cycle, then IDLE.
- Timing:
  - Plot for cell n is visible between E(n+1) and E(n+2).
  - Total latency from the accept edge to done is N+1 cycles.
  - Clear cells still take one cycle each, with plot=0.
- xout, yout and colour hold their last values while plot=0 or in IDLE.
- start while busy or during done is ignored; no queueing.
- start at the same edge as reset: reset wins.
- Input changes after accept have no effect on the current draw.
- SPR_W=1 or SPR_H=1 must work: single-row or single-column scan.
- All-zero bitmap: no plot pulses; done still occurs at E(N+1).
- Counter widths are $clog2 of SPR_W and SPR_H, minimum 1 bit.

Optional Feature:
- Macro: SPRITE_CLIP_EN.
- Defined:
  - A cell whose unwrapped x_base+c >= SCR_W, or y_base+r >= SCR_H, gets plot=0.
  - The sum is computed one bit wider than X_W/Y_W so overflow is detected.
  - Timing is unchanged.
- Undefined: coordinates wrap modulo 2^X_W and 2^Y_W, and SCR_W/SCR_H are unused.

Test Plan:
- Reset behaviour: SPR_W=4, SPR_H=2, hold reset 2 cycles -> all outputs 0, state IDLE; start asserted with reset -> still IDLE.
- Basic draw: SPR_W=4, SPR_H=2, bitmap=8'b1000_0001, x_base=10, y_base=20, fg_colour=3'b110, start 1 cycle -> exactly 2 plot pulses: (10,20) at E1 and (13,21) at E8, colour 110; done high after E9 only; busy high E0..E9.
- Erase mode: same bitmap, erase=1, BG_COLOUR=0 -> same coordinates with colour 000.
- Ignore start while busy: pulse start again at E3 with x_base=50 -> no restart, coordinates stay 10-based, single done.
- Mid-draw reset: reset at E4 -> plot, busy and done 0 next cycle; no done pulse; new start then draws normally.
- Wrap/clip: x_base=158, SPR_W=4, all-ones single row. Without SPRITE_CLIP_EN -> x = 158, 159, 160, 161 (8-bit wrap irrelevant). With SPRITE_CLIP_EN -> only 158 and 159 plotted. x_base=254 without the macro -> x = 254, 255, 0, 1.

Source files
------------

// File: rtl/sprite_plotter.sv
// Scans a SPR_W x SPR_H one-bit bitmap, one cell per clock, and issues VGA plot requests offset from a latched base.
// Optional macro SPRITE_CLIP_EN suppresses plots for cells that fall beyond SCR_W x SCR_H.
module sprite_plotter #(
    parameter int SPR_W     = 16,
    parameter int SPR_H     = 16,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COL_W     = 3,
    parameter int BG_COLOUR = 0,
    parameter int SCR_W     = 160,
    parameter int SCR_H     = 120
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [X_W-1:0]         x_base,
    input  logic [Y_W-1:0]         y_base,
    input  logic [SPR_W*SPR_H-1:0] bitmap,
    input  logic [COL_W-1:0]       fg_colour,
    input  logic                   erase,
    output logic [X_W-1:0]         xout,
    output logic [Y_W-1:0]         yout,
    output logic [COL_W-1:0]       colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);
    localparam int N  = SPR_W * SPR_H;
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;

    logic [CW-1:0]    c;
    logic [RW-1:0]    r;
    logic [N-1:0]     bm_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [COL_W-1:0] fg_q;
    logic             erase_q;

    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    logic         on_screen;
    logic         cell_on;
    logic         last_col;
    logic         last_cell;

    always_comb begin
        x_sum     = {1'b0, x_q} + (X_W+1)'(c);
        y_sum     = {1'b0, y_q} + (Y_W+1)'(r);
`ifdef SPRITE_CLIP_EN
        on_screen = (int'(x_sum) < SCR_W) && (int'(y_sum) < SCR_H);
`else
        on_screen = 1'b1;
`endif
        // The latched bitmap is shifted each cell, so bit 0 is always the current cell.
        cell_on   = bm_q[0] && on_screen;
        last_col  = (c == CW'(SPR_W - 1));
        last_cell = last_col && (r == RW'(SPR_H - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            c       <= '0;
            r       <= '0;
            bm_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fg_q    <= '0;
            erase_q <= 1'b0;
            xout    <= '0;
            yout    <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        bm_q    <= bitmap;
                        x_q     <= x_base;
                        y_q     <= y_base;
                        fg_q    <= fg_colour;
                        erase_q <= erase;
                        c       <= '0;
                        r       <= '0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    plot <= cell_on;
                    // Coordinates and colour only move when a pixel is actually written.
                    if (cell_on) begin
                        xout   <= x_sum[X_W-1:0];
                        yout   <= y_sum[Y_W-1:0];
                        colour <= erase_q ? COL_W'(BG_COLOUR) : fg_q;
                    end
                    bm_q <= bm_q >> 1;
                    if (last_col) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                    if (last_cell) state <= DONE;
                end
                DONE: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_plotter.sv
// Randomised bench for sprite_plotter (4x2 sprite) against a cell-by-cell reference model.
module tb_sprite_plotter;
    localparam int SPR_W = 4;
    localparam int SPR_H = 2;
    localparam int N     = SPR_W * SPR_H;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;
    localparam int BG    = 0;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int W     = 1 + X_W + Y_W + COL_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [X_W-1:0]   x_base;
    logic [Y_W-1:0]   y_base;
    logic [N-1:0]     bitmap;
    logic [COL_W-1:0] fg_colour;
    logic             erase;
    logic [X_W-1:0]   xout;
    logic [Y_W-1:0]   yout;
    logic [COL_W-1:0] colour;
    logic             plot;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    sprite_plotter #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W),
        .BG_COLOUR(BG), .SCR_W(SCR_W), .SCR_H(SCR_H)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .x_base(x_base), .y_base(y_base),
        .bitmap(bitmap), .fg_colour(fg_colour), .erase(erase),
        .xout(xout), .yout(yout), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else n_pass++;
    endtask

    // Reference: one entry per cell in row-major order, {plot, x, y, colour}.
    task automatic build_model(input int xb, input int yb, input logic [N-1:0] bm,
                               input int fg, input bit er);
        exp_q.delete();
        for (int n = 0; n < N; n++) begin
            int cx = xb + (n % SPR_W);
            int ry = yb + (n / SPR_W);
            bit p  = bm[n];
`ifdef SPRITE_CLIP_EN
            if (cx >= SCR_W || ry >= SCR_H) p = 1'b0;
`endif
            exp_q.push_back({p, X_W'(cx % (1 << X_W)), Y_W'(ry % (1 << Y_W)),
                             COL_W'(er ? BG : fg)});
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; x_base = '0; y_base = '0; bitmap = '0; fg_colour = '0; erase = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic launch(input int xb, input int yb, input logic [N-1:0] bm,
                          input int fg, input bit er);
        build_model(xb, yb, bm, fg, er);
        @(negedge clk);
        start = 1'b1; x_base = X_W'(xb); y_base = Y_W'(yb);
        bitmap = bm; fg_colour = COL_W'(fg); erase = er;
        @(negedge clk);
        check("accept_busy", busy, 1);
        check("accept_plot", plot, 0);
        start = 1'b0;
        x_base = X_W'($urandom); y_base = Y_W'($urandom);
        bitmap = N'($urandom); fg_colour = COL_W'($urandom); erase = 1'($urandom);
    endtask

    // restart_at > 0 re-asserts start (with a different base) after that many scan cycles.
    task automatic draw(input int xb, input int yb, input logic [N-1:0] bm,
                        input int fg, input bit er, input int restart_at);
        logic [W-1:0] e;
        launch(xb, yb, bm, fg, er);
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            check("plot", plot, e[W-1]);
            check("busy", busy, 1);
            check("done_early", done, 0);
            if (e[W-1]) begin
                check("xout", xout, e[W-2 -: X_W]);
                check("yout", yout, e[Y_W+COL_W-1 -: Y_W]);
                check("colour", colour, e[COL_W-1:0]);
            end
            if (k == restart_at) begin
                start = 1'b1; x_base = 8'd50;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("plot_end", plot, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("stay_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        do_reset();
        check("rst_xout", xout, 0);
        check("rst_yout", yout, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // start together with reset must not begin a draw
        @(negedge clk);
        reset = 1'b1; start = 1'b1; bitmap = '1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 0);
        @(negedge clk);
        check("rst_start_idle", busy, 0);
        check("rst_start_plot", plot, 0);

        draw(10, 20, 8'b1000_0001, 3'b110, 1'b0, 0);
        draw(10, 20, 8'b1000_0001, 3'b110, 1'b1, 0);
        draw(10, 20, 8'b1000_0001, 3'b110, 1'b0, 2);
        draw(30, 40, 8'h00, 3'b101, 1'b0, 0);
        draw(158, 5, 8'h0F, 3'b011, 1'b0, 0);
        draw(254, 127, 8'hFF, 3'b111, 1'b0, 0);

        // abort mid-draw: reset sampled at E4
        launch(10, 20, 8'hFF, 3'b110, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_no_busy", busy, 0);
        end
        draw(12, 3, 8'b0110_1001, 3'b001, 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            draw($urandom_range(0, 255), $urandom_range(0, 127), N'($urandom),
                 $urandom_range(0, 7), 1'($urandom), $urandom_range(0, N));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
